// File: rtl/load_store_unit.sv
// Purpose: turns byte/half/word loads and stores into aligned, byte-enabled word accesses on a handshaked data memory.
// Latency: 3 cycles (IDLE, BUSY, DONE) when mem_ack arrives in the first BUSY cycle; Stall is high for 2 of them.
// Backpressure: Stall holds the datapath until mem_ack arrives or TIMEOUT_CYC BUSY cycles pass (BusErr abort).
//
// Ports: clk/reset (async, active-low); MemRead/MemWrite/Funct3/Addr/WriteData from the datapath;
//        ReadData (registered load result), Stall, AccErr, BusErr to the datapath;
//        mem_req/mem_we/mem_addr/mem_be/mem_wdata to memory, mem_ack/mem_rdata from memory.
module load_store_unit #(
    parameter int DATA_W      = 32,
    parameter int DM_ADDRESS  = 9,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DM_ADDRESS-1:0] Addr,
    input  logic [DATA_W-1:0]     WriteData,
    output logic [DATA_W-1:0]     ReadData,
    output logic                  Stall,
    output logic                  AccErr,
    output logic                  BusErr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-3:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [DM_ADDRESS-3:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  acc_err_q, acc_err_d;
    logic                  bus_err_q, bus_err_d;

    logic                  access_c;
    logic                  legal_c;
    logic                  misalign_c;
    logic [3:0]            be_c;
    logic [DATA_W-1:0]     wdata_c;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_W-1:0]     load_ext;

    // A request with both strobes high is treated as a store.
    always_comb begin
        access_c   = MemRead | MemWrite;
        if (MemWrite) legal_c = Funct3 inside {3'b000, 3'b001, 3'b010};
        else          legal_c = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misalign_c = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                     ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));

        be_c    = 4'b1111;
        wdata_c = WriteData;
        if (MemWrite) begin
            case (Funct3[1:0])
                2'b00: begin
                    be_c    = 4'b0001 << Addr[1:0];
                    wdata_c = {4{WriteData[7:0]}};
                end
                2'b01: begin
                    be_c    = 4'b0011 << Addr[1:0];
                    wdata_c = {2{WriteData[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = WriteData;
                end
            endcase
        end
    end

    // Lane selection and extension use the size/offset latched at request time.
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(DATA_W-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(DATA_W-16){1'b0}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        off_d     = off_q;
        rdata_d   = rdata_q;
        acc_err_d = 1'b0;
        bus_err_d = 1'b0;
        Stall     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (access_c) begin
                    if (legal_c && !misalign_c) begin
                        Stall   = 1'b1;
                        req_d   = 1'b1;
                        we_d    = MemWrite;
                        addr_d  = Addr[DM_ADDRESS-1:2];
                        be_d    = be_c;
                        wdata_d = wdata_c;
                        f3_d    = Funct3;
                        off_d   = Addr[1:0];
                        state_d = BUSY;
                    end else begin
                        // Rejected without a bus cycle; the datapath is not stalled.
                        acc_err_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                Stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ack) begin
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = load_ext;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    if (!we_q) rdata_d = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // One unstalled cycle lets the datapath commit before the next request is considered.
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            rdata_q   <= '0;
            acc_err_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            rdata_q   <= rdata_d;
            acc_err_q <= acc_err_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign ReadData  = rdata_q;
    assign AccErr    = acc_err_q;
    assign BusErr    = bus_err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle datapath's ALU/register-file outputs and a word-wide, handshaked data memory.
- Converts byte, halfword and word loads and stores (selected by Funct3) into aligned word accesses with byte enables, and sign- or zero-extends load data.
- Stalls the datapath (holds the PC) while a memory access is outstanding, and flags misaligned or illegal accesses and bus timeouts.

Parameters:
- DATA_W, 32, data width; fixed at 32 (byte lanes assume 4).
- DM_ADDRESS, 9, byte address width from the ALU result.
- TIMEOUT_CYC, 15, maximum BUSY cycles waiting for mem_ack before abort; must be ≥1.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- reset, input, 1, asynchronous, active-low (0 = reset); deassertion is synchronous to clk at the system level.
- MemRead, input, 1, load request from the controller.
- MemWrite, input, 1, store request from the controller.
- Funct3, input, 3, access size and signedness.
- Addr, input, DM_ADDRESS, byte address (ALUResult[DM_ADDRESS-1:0]).
- WriteData, input, DATA_W, store data (Reg2).
- ReadData, output, DATA_W, extended load result, registered.
- Stall, output, 1, high means the datapath must hold the PC and register-file write.
- AccErr, output, 1, one-cycle pulse on a misaligned access or illegal Funct3.
- BusErr, output, 1, one-cycle pulse on a timeout abort.
- mem_req, output, 1, memory request, registered.
- mem_we, output, 1, 1 = write.
- mem_addr, output, DM_ADDRESS-2, word address (Addr[DM_ADDRESS-1:2]).
- mem_be, output, 4, byte enables.
- mem_wdata, output, DATA_W, lane-aligned store data.
- mem_ack, input, 1, access complete; mem_rdata is valid in the same cycle.
- mem_rdata, input, DATA_W, word read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadData, AccErr and BusErr all 0.
  - Reset mid-access drops mem_req immediately; the access is abandoned.
- Legal Funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned access: halfword with Addr[0]=1, or word with Addr[1:0]≠00.
- If MemRead and MemWrite are both 1, the access is a store; ReadData is unchanged.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Access requested and legal: latch mem_addr, mem_we, mem_be, mem_wdata and Funct3/Addr[1:0], set mem_req=1, go to BUSY. Stall=1 combinationally this cycle.
  - Access requested but illegal or misaligned: no request, AccErr=1 next cycle for 1 cycle, Stall=0, stay IDLE.
- BUSY:
  - Stall=1, and request fields stay stable.
  - Counter increments each cycle.
  - mem_ack=1 at an edge: mem_req←0; for a load, ReadData←extend(mem_rdata); go to DONE.
  - mem_ack low and counter=TIMEOUT_CYC-1: mem_req←0, BusErr pulse, ReadData←0 if the access is a load, go to DONE.
- DONE: Stall=0 for exactly one cycle so the datapath commits and advances; counter←0; go to IDLE unconditionally (the next instruction is evaluated in IDLE).
- Latency with ack in the first BUSY cycle: 3 cycles (IDLE, BUSY, DONE), of which 2 are stalled.
- Byte enables and store data (k=Addr[1:0]):
  - SB: be=0001<<k, wdata=replicate byte ×4.
  - SH: be=0011<<k, wdata=replicate half ×2.
  - SW: be=1111.
  - For loads, mem_be=1111.
- Load extension: select byte k or half k[1]; sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word unchanged.
- ReadData holds its last value between loads; stores never modify it.
- mem_ack outside BUSY is ignored.

Test Plan:
- Reset held low with mem_ack=1 → all outputs 0, state IDLE. Assert reset during BUSY → mem_req falls the same cycle and no DONE follows.
- LW Addr=0x008, mem_rdata=0xDEADBEEF, ack on the 1st BUSY cycle → mem_addr=0x02, be=1111, Stall high for 2 cycles then low 1 cycle, ReadData=0xDEADBEEF.
- LB Addr=0x003, mem_rdata=0x80123456 → ReadData=0xFFFFFF80. LBU with the same stimulus → ReadData=0x00000080. LHU Addr=0x002 → ReadData=0x00008012.
- SB Addr=0x005, WriteData=0x000000A5 → mem_we=1, be=0010, wdata=0xA5A5A5A5, mem_addr=0x01. SH Addr=0x006, WriteData=0x1234 → be=1100, wdata=0x12341234.
- LH Addr=0x001 → AccErr pulses 1 cycle, mem_req never asserts, Stall=0. Funct3=011 with MemRead=1 → same response.
- SW with mem_ack held low → BusErr pulses after exactly 15 BUSY cycles, mem_req drops, one DONE cycle, back to IDLE. Ack arriving 3 cycles later is ignored.
